// File: rtl/parking_gate_controller_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN_IN,
    OPEN_OUT,
    CLOSE
  } state_e;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic       DIR_ENTRY   = 1'b0;
  localparam logic       DIR_EXIT    = 1'b1;

  // Elaboration-time only: turns a 0..99 constant into {tens, ones}.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Request/status bundle between the gate loops, beam sensor, display and controller.
interface parking_gate_controller_if;
  logic       entry_req;
  logic       exit_req;
  logic       car_passed;
  logic       gate_open;
  logic       gate_dir;
  logic       busy;
  logic       full;
  logic       empty;
  logic [3:0] free_tens;
  logic [3:0] free_ones;
  logic       timeout_err;

  modport master (
    output entry_req, exit_req, car_passed,
    input  gate_open, gate_dir, busy, full, empty, free_tens, free_ones, timeout_err
  );

  modport slave (
    input  entry_req, exit_req, car_passed,
    output gate_open, gate_dir, busy, full, empty, free_tens, free_ones, timeout_err
  );
endinterface

// File: rtl/parking_gate_controller_bcd_updown_counter.sv
// Two-digit BCD up/down counter with digit carry/borrow and saturation at 0 and MAX_VALUE.
module bcd_updown_counter
  import parking_pkg::*;
#(
  parameter int unsigned MAX_VALUE   = 20,
  parameter int unsigned RESET_VALUE = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       at_zero,
  output logic       at_max
);

  localparam logic [7:0] MAX_BCD   = to_bcd(MAX_VALUE);
  localparam logic [7:0] RESET_BCD = to_bcd(RESET_VALUE);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_zero_q, at_zero_d;
  logic       at_max_q, at_max_d;

  // Flags are computed from the next value so they land on the same edge as the digits.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc && !at_max_q) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec && !at_zero_q) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
    at_zero_d = ({tens_d, ones_d} == 8'h00);
    at_max_d  = ({tens_d, ones_d} == MAX_BCD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q    <= RESET_BCD[7:4];
      ones_q    <= RESET_BCD[3:0];
      at_zero_q <= (RESET_BCD == 8'h00);
      at_max_q  <= (RESET_BCD == MAX_BCD);
    end else begin
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      at_zero_q <= at_zero_d;
      at_max_q  <= at_max_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign at_zero = at_zero_q;
  assign at_max  = at_max_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier sequencer with BCD free-space count.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit on the display.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY         = 20,
  parameter int unsigned GATE_OPEN_CYCLES = 50,
  parameter int unsigned TIMER_W          = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  parking_gate_controller_if.slave bus
);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 gate_open_q, gate_open_d;
  logic                 gate_dir_q, gate_dir_d;
  logic                 busy_q, busy_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 cnt_inc, cnt_dec;
  logic [3:0]           cnt_tens;

  // Exit wins arbitration; a pass and a window expiry in the same cycle count as a pass.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    gate_dir_d    = gate_dir_q;
    timeout_err_d = 1'b0;
    cnt_inc       = 1'b0;
    cnt_dec       = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (bus.exit_req && !bus.empty) begin
          state_d    = OPEN_OUT;
          gate_dir_d = DIR_EXIT;
        end else if (bus.entry_req && !bus.full) begin
          state_d    = OPEN_IN;
          gate_dir_d = DIR_ENTRY;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (bus.car_passed) begin
          cnt_dec = (state_q == OPEN_IN);
          cnt_inc = (state_q == OPEN_OUT);
          state_d = CLOSE;
        end else if (timer_q == TIMER_W'(GATE_OPEN_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = CLOSE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      CLOSE: begin
        timer_d = '0;
        state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
    gate_open_d = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      gate_open_q   <= 1'b0;
      gate_dir_q    <= DIR_ENTRY;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      gate_open_q   <= gate_open_d;
      gate_dir_q    <= gate_dir_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  bcd_updown_counter #(
    .MAX_VALUE   (CAPACITY),
    .RESET_VALUE (CAPACITY)
  ) u_free_count (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .dec     (cnt_dec),
    .tens    (cnt_tens),
    .ones    (bus.free_ones),
    .at_zero (bus.full),
    .at_max  (bus.empty)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign bus.free_tens = (cnt_tens == 4'd0) ? BLANK_DIGIT : cnt_tens;
`else
  assign bus.free_tens = cnt_tens;
`endif

  assign bus.gate_open   = gate_open_q;
  assign bus.gate_dir    = gate_dir_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: each gate cycle queues its expected outcome,
// and a monitor checks it when the gate closes.
module tb_parking_gate_controller;
  import parking_pkg::*;

  localparam int CAP = 20;
  localparam int GOC = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  parking_gate_controller_if bus();

  parking_gate_controller #(
    .CAPACITY         (CAP),
    .GATE_OPEN_CYCLES (GOC),
    .TIMER_W          (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         dir;
    bit         timeout;
    int         open_len;
    logic [3:0] tens;
    logic [3:0] ones;
    bit         full;
    bit         empty;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   assertCount = 0;
  int   failCount   = 0;
  int   freeModel   = CAP;
  bit   prevOpen    = 1'b0;
  int   openLen     = 0;
  bit   gotDir      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] dispTens(input int f);
`ifdef LEADING_ZERO_BLANK_EN
    if (f < 10) return 4'hF;
`endif
    return 4'(f / 10);
  endfunction

  function automatic exp_t makeExp(input bit dir, input bit to, input int len);
    exp_t e;
    e.dir      = dir;
    e.timeout  = to;
    e.open_len = len;
    e.tens     = dispTens(freeModel);
    e.ones     = 4'(freeModel % 10);
    e.full     = (freeModel == 0);
    e.empty    = (freeModel == CAP);
    return e;
  endfunction

  task automatic waitGate(input bit level, input int budget, input string name);
    int n = 0;
    while (bus.gate_open !== level && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(bus.gate_open), 32'(level));
  endtask

  // One gate cycle; passDelay 0 means no car ever passes, so the window times out.
  task automatic applyStimulus(input bit ent, input bit ext, input int passDelay, input bit hold);
    bit dir;
    bit to;
    dir = ext && (freeModel < CAP);
    to  = (passDelay == 0);
    if (!to) freeModel += dir ? 1 : -1;
    exp_q.push_back(makeExp(dir, to, to ? GOC : passDelay));
    bus.entry_req = ent;
    bus.exit_req  = ext;
    waitGate(1'b1, 20, "gate_opens");
    if (!hold) begin
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
    end
    if (!to) begin
      repeat (passDelay - 1) begin
        @(posedge clk);
        #1;
      end
      bus.car_passed = 1'b1;
      @(posedge clk);
      #1;
      bus.car_passed = 1'b0;
    end
    waitGate(1'b0, GOC + 10, "gate_closes");
  endtask

  // Monitor: measures each open window and checks it against the queued expectation on close.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevOpen = 1'b0;
      openLen  = 0;
    end else begin
      if (bus.gate_open && !prevOpen) begin
        openLen = 1;
        gotDir  = bus.gate_dir;
      end else if (bus.gate_open) begin
        openLen++;
      end
      if (!bus.gate_open && prevOpen) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_close", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sb_dir",      32'(gotDir),          32'(mon_e.dir));
          checkOutput("sb_open_len", 32'(openLen),         32'(mon_e.open_len));
          checkOutput("sb_timeout",  32'(bus.timeout_err), 32'(mon_e.timeout));
          checkOutput("sb_tens",     32'(bus.free_tens),   32'(mon_e.tens));
          checkOutput("sb_ones",     32'(bus.free_ones),   32'(mon_e.ones));
          checkOutput("sb_full",     32'(bus.full),        32'(mon_e.full));
          checkOutput("sb_empty",    32'(bus.empty),       32'(mon_e.empty));
        end
      end else if (bus.timeout_err) begin
        checkOutput("stray_timeout", 32'(bus.timeout_err), 32'd0);
      end
      prevOpen = bus.gate_open;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit everOpened;
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_tens",      32'(bus.free_tens),   32'(dispTens(CAP)));
    checkOutput("rst_ones",      32'(bus.free_ones),   32'd0);
    checkOutput("rst_empty",     32'(bus.empty),       32'd1);
    checkOutput("rst_full",      32'(bus.full),        32'd0);
    checkOutput("rst_gate_open", 32'(bus.gate_open),   32'd0);
    checkOutput("rst_busy",      32'(bus.busy),        32'd0);
    checkOutput("rst_timeout",   32'(bus.timeout_err), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Held entry: pass on 3rd open cycle, then reopen after the close
    freeModel = 19;
    exp_q.push_back(makeExp(DIR_ENTRY, 1'b0, 3));
    bus.entry_req = 1'b1;
    waitGate(1'b1, 20, "t2_open");
    checkOutput("t2_dir", 32'(bus.gate_dir), 32'(DIR_ENTRY));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.car_passed = 1'b1;
    @(posedge clk);
    #1;
    bus.car_passed = 1'b0;
    checkOutput("t2_close_cycle", 32'(bus.gate_open), 32'd0);
    checkOutput("t2_tens_19",     32'(bus.free_tens), 32'd1);
    checkOutput("t2_ones_19",     32'(bus.free_ones), 32'd9);
    checkOutput("t2_not_empty",   32'(bus.empty),     32'd0);
    freeModel = 18;
    exp_q.push_back(makeExp(DIR_ENTRY, 1'b0, 1));
    waitGate(1'b1, 3, "t2_reopen");
    bus.entry_req  = 1'b0;
    bus.car_passed = 1'b1;
    @(posedge clk);
    #1;
    bus.car_passed = 1'b0;
    waitGate(1'b0, 5, "t2_closed");

    // Fill to capacity, then a held entry must be ignored
    while (freeModel > 0) applyStimulus(1'b1, 1'b0, 2, 1'b0);
    checkOutput("t3_full",  32'(bus.full),      32'd1);
    checkOutput("t3_tens",  32'(bus.free_tens), 32'(dispTens(0)));
    checkOutput("t3_ones",  32'(bus.free_ones), 32'd0);
    everOpened    = 1'b0;
    bus.entry_req = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.gate_open || bus.busy) everOpened = 1'b1;
    end
    bus.entry_req = 1'b0;
    checkOutput("t3_full_stays_closed", 32'(everOpened), 32'd0);

    // Bring to 5 free, then simultaneous requests: exit wins
    repeat (5) applyStimulus(1'b0, 1'b1, 1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2, 1'b0);
    checkOutput("t4_ones_6", 32'(bus.free_ones), 32'd6);
    checkOutput("t4_tens_0", 32'(bus.free_tens), 32'(dispTens(6)));

    // Timeout: no car_passed, 50-cycle window, count unchanged
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("t5_ones_unchanged", 32'(bus.free_ones), 32'd6);

    // Reset while the gate is open at 12 free
    repeat (6) applyStimulus(1'b0, 1'b1, 1, 1'b0);
    checkOutput("t6_tens_12", 32'(bus.free_tens), 32'd1);
    checkOutput("t6_ones_12", 32'(bus.free_ones), 32'd2);
    bus.entry_req = 1'b1;
    waitGate(1'b1, 20, "t6_open");
    bus.entry_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_gate", 32'(bus.gate_open), 32'd0);
    checkOutput("t6_async_busy", 32'(bus.busy),      32'd0);
    checkOutput("t6_async_tens", 32'(bus.free_tens), 32'(dispTens(CAP)));
    checkOutput("t6_async_ones", 32'(bus.free_ones), 32'd0);
    checkOutput("t6_async_empty", 32'(bus.empty),    32'd1);
    freeModel = CAP;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Down to 9 free: tens digit shows blank only when leading-zero blanking is built in
    repeat (11) applyStimulus(1'b1, 1'b0, 1, 1'b0);
    checkOutput("blank_tens_9", 32'(bus.free_tens), 32'(dispTens(9)));
    checkOutput("blank_ones_9", 32'(bus.free_ones), 32'd9);

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Sequences the single entry/exit barrier of the parking facility and keeps the free-space count.
- Arbitrates between entry and exit requests and times the gate-open window.
- Presents the free-space count as two registered BCD digits (tens, ones) that feed the facility's seven-segment decoders directly.
- Codes 4'hA–4'hF on a digit are blanked by the downstream decoders.

Parameters:
- CAPACITY, 20, total spaces; legal range 1..99.
- GATE_OPEN_CYCLES, 50, maximum cycles the gate stays open waiting for car_passed; must be ≥ 2.
- TIMER_W, 8, width of the gate timer; must satisfy 2^TIMER_W > GATE_OPEN_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entry_req  input  1  level; car waiting at entry loop.
- exit_req  input  1  level; car waiting at exit loop.
- car_passed  input  1  single-cycle pulse from the gate beam sensor.
- gate_open  output  1  registered; barrier raised.
- gate_dir  output  1  registered; 0 = entry, 1 = exit; valid while gate_open = 1.
- busy  output  1  registered; FSM not in IDLE.
- full  output  1  registered; free count == 0.
- empty  output  1  registered; free count == CAPACITY.
- free_tens  output  4  registered BCD tens digit of the free count.
- free_ones  output  4  registered BCD ones digit of the free count.
- timeout_err  output  1  registered single-cycle pulse when the gate window expires without car_passed.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; gate_open = 0; gate_dir = 0; busy = 0; timeout_err = 0; timer = 0.
  - Free count = CAPACITY, so free_tens/free_ones = BCD of CAPACITY.
  - empty = 1; full = 0.
  - Reset mid-operation aborts the cycle: gate closes immediately and no count change is applied.
- FSM states: IDLE, OPEN_IN, OPEN_OUT, CLOSE.
- IDLE:
  - Exit has priority.
  - If exit_req && !empty → OPEN_OUT, gate_dir = 1.
  - Else if entry_req && !full → OPEN_IN, gate_dir = 0.
  - Otherwise stay in IDLE.
  - exit_req while empty is ignored. entry_req while full is ignored.
  - The decision is made in the cycle the request is sampled. gate_open rises on the next edge (1-cycle latency).
- OPEN_IN / OPEN_OUT:
  - gate_open = 1; timer increments every cycle from 0.
  - car_passed = 1 → count update (OPEN_IN: free − 1; OPEN_OUT: free + 1), then → CLOSE.
  - timer == GATE_OPEN_CYCLES−1 without car_passed → timeout_err pulses 1 cycle, no count change, → CLOSE.
  - car_passed and expiry in the same cycle: the pass wins and no timeout_err is raised.
  - Requests arriving in these states are held off; they are not queued.
- CLOSE:
  - gate_open = 0; lasts exactly 1 cycle; timer cleared; → IDLE.
  - A still-asserted request is re-arbitrated in IDLE.
- car_passed outside OPEN_IN/OPEN_OUT is ignored.
- Count arithmetic:
  - The count is held as a BCD pair and updated with digit carry/borrow; no binary divide.
  - Decrement of ones 0 → 9 borrows from tens. Increment of ones 9 → 0 carries into tens.
  - The count saturates at 0 and CAPACITY. The FSM guards normally prevent reaching these limits; saturation is a defensive backstop.
- Flag and digit timing:
  - full, empty and the digits update on the same edge as the count change.
  - They are visible 1 cycle after car_passed.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the tens digit is 0, free_tens is driven with 4'hF, so the decoder blanks it. Example: 7 free shows blank/7.
- Not defined: free_tens is always the true BCD digit. Example: 7 free shows 0/7.
- free_ones and all internal state are unaffected in both cases.

Decomposition:
- Package parking_pkg:
  - state enum (IDLE, OPEN_IN, OPEN_OUT, CLOSE);
  - BLANK_DIGIT = 4'hF;
  - DIR_ENTRY = 1'b0, DIR_EXIT = 1'b1;
  - helper function converting a 0..99 constant to a BCD pair, used for the reset value.
- One sub-module: bcd_updown_counter.
  - Two-digit BCD with inc/dec strobes, async reset to a parameterised value, saturation at 0 and a parameterised max.
  - Outputs tens, ones, at_zero, at_max.

Test Plan:
1. Reset with CAPACITY=20 → free_tens/free_ones = 2/0, empty = 1, full = 0, gate_open = 0.
2. entry_req held, car_passed pulsed on the 3rd cycle after gate_open rises:
   - gate_open rises 1 cycle after the request; free shows 1/9 one cycle after the pulse;
   - gate_open is low for 1 CLOSE cycle, then reopens because entry_req is still high.
3. Fill to CAPACITY with 20 entries → full = 1, digits 0/0; a further entry_req leaves gate_open = 0 indefinitely.
4. entry_req and exit_req asserted in the same cycle at free = 5 → gate_dir = 1 (exit served), free becomes 0/6 after car_passed.
5. entry_req with no car_passed, GATE_OPEN_CYCLES = 50 → gate_open high for exactly 50 cycles, one timeout_err pulse, count unchanged.
6. rst_n low while gate_open = 1 at free = 1/2 → gate_open = 0 asynchronously, digits return to 2/0; with LEADING_ZERO_BLANK_EN defined, free = 9 shows free_tens = 4'hF.
